// File: rtl/div_16b_seq.sv
// Iterative unsigned 16-bit restoring divider, one shift-and-trial-subtract per cycle.
// Each trial subtraction is S + ~divisor + 1 on an rca_16b instance.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, sampled only while busy==0
//   dividend, divisor operands, captured when start is accepted
//   busy              high while an operation is in progress
//   done              one-cycle completion pulse
//   quotient          result quotient, held until the next completion
//   remainder         result remainder, held until the next completion
//   div_by_zero       set with done when the captured divisor was zero

// 16-bit ripple-carry adder used for the trial subtraction.
// Ports: a, b operands; c_in carry in; sum result; c_out carry out.
module rca_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [16:0] c;

    // Full-adder chain, LSB first.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i < 16; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c_out = c[16];
    end
endmodule

module div_16b_seq #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DZ   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   dvd_q, dvd_d;     // dividend bits out at MSB, quotient bits in at LSB
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N:0]     p_q, p_d;         // partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;

    logic [N:0]     s;
    logic [N-1:0]   dvs_n;
    logic [N-1:0]   t;
    logic           c_out;
    logic           ge;

    // Trial subtraction of the divisor from the shifted partial remainder.
    assign s     = {p_q[N-1:0], dvd_q[N-1]};
    assign dvs_n = ~dvs_q;

    rca_16b u_rca (
        .a     (s[N-1:0]),
        .b     (dvs_n),
        .c_in  (1'b1),
        .sum   (t),
        .c_out (c_out)
    );

    // S[N] set means S already exceeds any 16-bit divisor.
    assign ge = s[N] | c_out;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    p_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = (divisor == '0) ? DZ : RUN;
                end
            end
            RUN: begin
                dvd_d = {dvd_q[N-2:0], ge};
                p_d   = ge ? {1'b0, t} : s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = {dvd_q[N-2:0], ge};
                    rem_d   = ge ? t : s[N-1:0];
                end
            end
            DZ: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dbz_d   = 1'b1;
                quo_d   = '1;
                rem_d   = dvd_q;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
endmodule
